ifu_inst_buf: RTL and testbench

- Instruction buffer directly downstream of the IFU; decouples AXI fetch returns from the decode stage.
- Accepts {pc, instruction, bus error} beats from the IFU on a valid/ready handshake.
- Holds up to DEPTH entries in order and presents them to the IDU on a second valid/ready handshake.
- Supports a single-cycle flush on branch/exception redirect.

---
 rtl/ifu_inst_buf_pkg.sv | 15 +
 rtl/ifu_inst_buf_mem.sv | 25 ++
 rtl/ifu_inst_buf.sv | 98 +++++++++
 tb/tb_ifu_inst_buf.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_inst_buf_pkg.sv
// Shared constants for the IFU instruction buffer.
// IFU_INST_BUF_BYPASS_EN (in ifu_inst_buf) selects the zero-latency empty-buffer bypass.
package ifu_inst_buf_pkg;

  localparam int IFU_INST_BUF_DEPTH = 4;
  localparam int INST_WIDTH         = 32;
  localparam int AXI_ADDR_WIDTH     = 32;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // One extra pointer bit distinguishes full from empty when the indices match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifu_inst_buf_mem.sv
// Entry storage for the instruction buffer: one write port, one combinational read port.
// Contents are never reset; occupancy tracking lives in ifu_inst_buf.
module ifu_inst_buf_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ifu_inst_buf.sv
// In-order IFU->IDU instruction buffer with flush; pointers carry a wrap bit.
// Define IFU_INST_BUF_BYPASS_EN to forward IFU beats straight to the IDU when empty.
module ifu_inst_buf
  import ifu_inst_buf_pkg::*;
#(
  parameter int DEPTH      = IFU_INST_BUF_DEPTH,
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int INST_WIDTH = ifu_inst_buf_pkg::INST_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       ifu_inst_valid,
  output logic                       ifu_inst_ready,
  input  logic [ADDR_WIDTH-1:0]      ifu_inst_pc,
  input  logic [INST_WIDTH-1:0]      ifu_inst_data,
  input  logic                       ifu_inst_err,
  output logic                       idu_inst_valid,
  input  logic                       idu_inst_ready,
  output logic [ADDR_WIDTH-1:0]      idu_inst_pc,
  output logic [INST_WIDTH-1:0]      idu_inst_data,
  output logic                       idu_inst_err,
  output logic [$clog2(DEPTH):0]     buf_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam int EW = ADDR_WIDTH + INST_WIDTH + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          empty, full;
  logic          push, push_wr, pop_mem, mem_valid;
  logic [EW-1:0] rdata;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [INST_WIDTH-1:0] head_data;
  logic                  head_err;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);

  // rst_n gating keeps ready low while held in reset, when the pointers alone look "not full".
  assign ifu_inst_ready = rst_n & enable & ~full & ~flush;
  assign push           = ifu_inst_valid & ifu_inst_ready;
  assign mem_valid      = enable & ~empty & ~flush;

  ifu_inst_buf_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push_wr),
    .waddr (wr_ptr_q[IW-1:0]),
    .wdata ({ifu_inst_pc, ifu_inst_data, ifu_inst_err}),
    .raddr (rd_ptr_q[IW-1:0]),
    .rdata (rdata)
  );

  assign {head_pc, head_data, head_err} = rdata;

`ifdef IFU_INST_BUF_BYPASS_EN
  logic byp;

  assign byp            = rst_n & empty & ifu_inst_valid & enable & ~flush;
  assign idu_inst_valid = mem_valid | byp;
  assign idu_inst_pc    = !rst_n ? '0 : (byp ? ifu_inst_pc   : head_pc);
  assign idu_inst_data  = !rst_n ? '0 : (byp ? ifu_inst_data : head_data);
  assign idu_inst_err   = rst_n & (byp ? ifu_inst_err : head_err);
  // A bypassed beat taken by decode this cycle never occupies a slot.
  assign push_wr        = push & ~(byp & idu_inst_ready);
  assign pop_mem        = mem_valid & idu_inst_ready;
`else
  assign idu_inst_valid = mem_valid;
  assign idu_inst_pc    = rst_n ? head_pc   : '0;
  assign idu_inst_data  = rst_n ? head_data : '0;
  assign idu_inst_err   = rst_n & head_err;
  assign push_wr        = push;
  assign pop_mem        = idu_inst_valid & idu_inst_ready;
`endif

  // Flush zeroes both pointers; push/pop are already suppressed during flush.
  assign wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push_wr);
  assign rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop_mem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign buf_count = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_ifu_inst_buf.sv
// Self-checking bench for ifu_inst_buf: directed vector table, async-reset sequence,
// then randomized traffic against a queue-based reference model.
module tb_ifu_inst_buf;

  localparam int DEPTH = 4;
`ifdef IFU_INST_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic        ifu_inst_valid;
  logic        ifu_inst_ready;
  logic [31:0] ifu_inst_pc;
  logic [31:0] ifu_inst_data;
  logic        ifu_inst_err;
  logic        idu_inst_valid;
  logic        idu_inst_ready;
  logic [31:0] idu_inst_pc;
  logic [31:0] idu_inst_data;
  logic        idu_inst_err;
  logic [2:0]  buf_count;

  ifu_inst_buf #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (32),
    .INST_WIDTH (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .flush          (flush),
    .ifu_inst_valid (ifu_inst_valid),
    .ifu_inst_ready (ifu_inst_ready),
    .ifu_inst_pc    (ifu_inst_pc),
    .ifu_inst_data  (ifu_inst_data),
    .ifu_inst_err   (ifu_inst_err),
    .idu_inst_valid (idu_inst_valid),
    .idu_inst_ready (idu_inst_ready),
    .idu_inst_pc    (idu_inst_pc),
    .idu_inst_data  (idu_inst_data),
    .idu_inst_err   (idu_inst_err),
    .buf_count      (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en, fl, iv, ir;
    logic [31:0] pc, data;
    logic        err;
    logic        e_rdy, e_val;
    logic [31:0] e_pc, e_data;
    logic        e_err;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[25];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [64:0] model_q[$];

  function automatic vec_t mk(input logic en, fl, iv, ir, input logic [31:0] pc, data,
                              input logic err, e_rdy, e_val, input logic [31:0] e_pc, e_data,
                              input logic e_err, input logic [2:0] e_cnt);
    vec_t v;
    v.en = en; v.fl = fl; v.iv = iv; v.ir = ir; v.pc = pc; v.data = data; v.err = err;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_pc = e_pc; v.e_data = e_data;
    v.e_err = e_err; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, fl, iv, ir, input logic [31:0] pc, data, input logic err);
    enable = en; flush = fl; ifu_inst_valid = iv; idu_inst_ready = ir;
    ifu_inst_pc = pc; ifu_inst_data = data; ifu_inst_err = err;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    drive(v.en, v.fl, v.iv, v.ir, v.pc, v.data, v.err);
    #3;
    $display("vec %0d: en=%0d fl=%0d iv=%0d ir=%0d pc=%h -> rdy=%0d val=%0d pc=%h cnt=%0d",
             idx, v.en, v.fl, v.iv, v.ir, v.pc, ifu_inst_ready, idu_inst_valid, idu_inst_pc, buf_count);
    chk($sformatf("vec%0d.ifu_ready", idx), 64'(ifu_inst_ready), 64'(v.e_rdy));
    chk($sformatf("vec%0d.idu_valid", idx), 64'(idu_inst_valid), 64'(v.e_val));
    chk($sformatf("vec%0d.count", idx), 64'(buf_count), 64'(v.e_cnt));
    if (v.e_val) begin
      chk($sformatf("vec%0d.pc", idx), 64'(idu_inst_pc), 64'(v.e_pc));
      chk($sformatf("vec%0d.data", idx), 64'(idu_inst_data), 64'(v.e_data));
      chk($sformatf("vec%0d.err", idx), 64'(idu_inst_err), 64'(v.e_err));
    end
  endtask

  initial begin
    //            en fl iv ir pc            data          err  rdy val  exp_pc        exp_data      err cnt
    vecs[0]  = mk(1, 0, 1, 0, 32'h4000_0000, 32'h0000_0013, 0,  1, BYP, 32'h4000_0000, 32'h0000_0013, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 32'h0,         32'h0,         0,  1, 1,   32'h4000_0000, 32'h0000_0013, 0, 1);
    vecs[2]  = mk(1, 0, 1, 0, 32'h4000_0004, 32'h11,        0,  1, 1,   32'h4000_0000, 32'h0000_0013, 0, 1);
    vecs[3]  = mk(1, 0, 1, 0, 32'h4000_0008, 32'h22,        0,  1, 1,   32'h4000_0000, 32'h0000_0013, 0, 2);
    vecs[4]  = mk(1, 0, 1, 0, 32'h4000_000C, 32'h33,        0,  1, 1,   32'h4000_0000, 32'h0000_0013, 0, 3);
    vecs[5]  = mk(1, 0, 1, 0, 32'h4000_0010, 32'h44,        0,  0, 1,   32'h4000_0000, 32'h0000_0013, 0, 4);
    vecs[6]  = mk(1, 0, 1, 1, 32'h4000_0010, 32'h44,        0,  0, 1,   32'h4000_0000, 32'h0000_0013, 0, 4);
    vecs[7]  = mk(1, 0, 1, 1, 32'h4000_0010, 32'h44,        0,  1, 1,   32'h4000_0004, 32'h11,        0, 3);
    vecs[8]  = mk(1, 0, 0, 1, 32'h0,         32'h0,         0,  1, 1,   32'h4000_0008, 32'h22,        0, 3);
    vecs[9]  = mk(0, 0, 1, 1, 32'h0000_0099, 32'h99,        0,  0, 0,   32'h0,         32'h0,         0, 2);
    vecs[10] = mk(1, 0, 1, 1, 32'h4000_0014, 32'h55,        0,  1, 1,   32'h4000_000C, 32'h33,        0, 2);
    vecs[11] = mk(1, 0, 1, 1, 32'h4000_0018, 32'h66,        0,  1, 1,   32'h4000_0010, 32'h44,        0, 2);
    vecs[12] = mk(1, 0, 1, 1, 32'h4000_001C, 32'h77,        0,  1, 1,   32'h4000_0014, 32'h55,        0, 2);
    vecs[13] = mk(1, 0, 1, 1, 32'h4000_0020, 32'hDEAD_BEEF, 1,  1, 1,   32'h4000_0018, 32'h66,        0, 2);
    vecs[14] = mk(1, 0, 1, 1, 32'h4000_0024, 32'h99,        0,  1, 1,   32'h4000_001C, 32'h77,        0, 2);
    vecs[15] = mk(1, 0, 1, 1, 32'h4000_0028, 32'hAA,        0,  1, 1,   32'h4000_0020, 32'hDEAD_BEEF, 1, 2);
    vecs[16] = mk(1, 0, 1, 0, 32'h4000_002C, 32'hBB,        0,  1, 1,   32'h4000_0024, 32'h99,        0, 2);
    vecs[17] = mk(1, 1, 1, 1, 32'h4000_0030, 32'hCC,        0,  0, 0,   32'h0,         32'h0,         0, 3);
    vecs[18] = mk(1, 0, 0, 0, 32'h0,         32'h0,         0,  1, 0,   32'h0,         32'h0,         0, 0);
    vecs[19] = mk(1, 0, 1, 0, 32'h4000_0034, 32'hDD,        0,  1, BYP, 32'h4000_0034, 32'hDD,        0, 0);
    vecs[20] = mk(1, 0, 0, 1, 32'h0,         32'h0,         0,  1, 1,   32'h4000_0034, 32'hDD,        0, 1);
    vecs[21] = mk(1, 0, 0, 0, 32'h0,         32'h0,         0,  1, 0,   32'h0,         32'h0,         0, 0);
    vecs[22] = mk(1, 0, 1, 1, 32'h4000_0010, 32'h13,        0,  1, BYP, 32'h4000_0010, 32'h13,        0, 0);
    vecs[23] = mk(1, 0, 0, 1, 32'h0,         32'h0,         0,  1, !BYP, 32'h4000_0010, 32'h13,       0, BYP ? 3'd0 : 3'd1);
    vecs[24] = mk(1, 0, 0, 0, 32'h0,         32'h0,         0,  1, 0,   32'h0,         32'h0,         0, 0);

    // Held in reset with a valid beat offered: everything must stay quiet.
    rst_n = 1'b0;
    drive(1, 0, 1, 1, 32'h4000_0000, 32'h13, 1);
    #12;
    chk("reset.ifu_ready", 64'(ifu_inst_ready), 64'd0);
    chk("reset.idu_valid", 64'(idu_inst_valid), 64'd0);
    chk("reset.pc", 64'(idu_inst_pc), 64'd0);
    chk("reset.data", 64'(idu_inst_data), 64'd0);
    chk("reset.err", 64'(idu_inst_err), 64'd0);
    chk("reset.count", 64'(buf_count), 64'd0);
    #5;
    drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      apply(vecs[i], i);
    end

    // Asynchronous reset mid-cycle discards buffered entries immediately.
    @(posedge clk); #1; drive(1, 0, 1, 0, 32'h4000_0050, 32'h50, 0);
    @(posedge clk); #1; drive(1, 0, 1, 0, 32'h4000_0054, 32'h54, 0);
    @(posedge clk); #1; drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
    #2;
    chk("arst.count_before", 64'(buf_count), 64'd2);
    chk("arst.valid_before", 64'(idu_inst_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    $display("arst: rst_n low mid-cycle -> val=%0d cnt=%0d", idu_inst_valid, buf_count);
    chk("arst.count", 64'(buf_count), 64'd0);
    chk("arst.idu_valid", 64'(idu_inst_valid), 64'd0);
    chk("arst.ifu_ready", 64'(ifu_inst_ready), 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #4;
    chk("arst.count_after", 64'(buf_count), 64'd0);
    chk("arst.valid_after", 64'(idu_inst_valid), 64'd0);
    chk("arst.ready_after", 64'(ifu_inst_ready), 64'd1);

    // Randomized traffic against a queue model of the buffer.
    model_q.delete();
    for (int c = 0; c < 400; c++) begin
      logic        en, fl, iv, ir, err, e_rdy, e_val, byp_now, do_push, do_pop;
      logic [31:0] pc, data;
      logic [64:0] beat, head;
      int          sz;
      @(posedge clk);
      #1;
      en   = ($urandom_range(0, 9) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 2) != 0);
      ir   = ($urandom_range(0, 2) != 0);
      pc   = $urandom;
      data = $urandom;
      err  = ($urandom_range(0, 7) == 0);
      drive(en, fl, iv, ir, pc, data, err);
      #3;
      beat    = {pc, data, err};
      sz      = model_q.size();
      e_rdy   = en && !fl && (sz < DEPTH);
      byp_now = BYP && en && !fl && (sz == 0) && iv;
      e_val   = en && !fl && ((sz > 0) || byp_now);
      head    = (sz > 0) ? model_q[0] : beat;
      chk($sformatf("rnd%0d.ifu_ready", c), 64'(ifu_inst_ready), 64'(e_rdy));
      chk($sformatf("rnd%0d.idu_valid", c), 64'(idu_inst_valid), 64'(e_val));
      chk($sformatf("rnd%0d.count", c), 64'(buf_count), 64'(sz));
      if (e_val) begin
        chk($sformatf("rnd%0d.head", c), 64'({idu_inst_pc, idu_inst_data, idu_inst_err}), head[63:0]);
        chk($sformatf("rnd%0d.head_pc_msb", c), 64'(idu_inst_pc[31]), 64'(head[64]));
      end
      if (fl) begin
        model_q.delete();
      end else begin
        do_push = iv && e_rdy;
        do_pop  = e_val && ir;
        if (do_pop) begin
          $display("rnd %0d: idu took pc=%h data=%h err=%0d", c, head[64:33], head[32:1], head[0]);
          if (sz > 0) void'(model_q.pop_front());
          else do_push = 1'b0;
        end
        if (do_push) model_q.push_back(beat);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
